// File: rtl/bcd_convert_arbiter.sv
// Round-robin arbiter that time-shares one binary-to-BCD converter among NREQ requesters.
// Optional conversion watchdog compiled in with `define BCD_ARB_WATCHDOG_EN.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | no conversion in flight; picks next requester from ptr
// ISSUE     | start pulse is on the wire; operand latched in conv_val
// WAIT_CLR  | waits for conv_done to drop, absorbing a stale done
// WAIT_DONE | waits for the fresh conv_done, then captures the result
// DELIVER   | ack pulse cycle; pointer moves past the winner
module bcd_convert_arbiter #(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 256
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req,
  input  logic [16*NREQ-1:0]   req_val,
  output logic [NREQ-1:0]      ack,
  output logic [15:0]          res_bcd,
  output logic                 err,
  output logic                 busy,
  output logic                 conv_start,
  output logic [15:0]          conv_val,
  input  logic                 conv_done,
  input  logic [15:0]          conv_bcd
);

  localparam int IW = $clog2(NREQ);

  if (NREQ < 2 || NREQ > 8 || TIMEOUT < 4 || TIMEOUT > 65535) begin : g_param_check
    $error("bcd_convert_arbiter: NREQ or TIMEOUT out of range");
  end

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_ISSUE     = 3'd1,
    S_WAIT_CLR  = 3'd2,
    S_WAIT_DONE = 3'd3,
    S_DELIVER   = 3'd4
  } state_t;

  state_t          state, state_nxt;
  logic [IW-1:0]   ptr, ptr_nxt;
  logic [IW-1:0]   gidx, gidx_nxt;
  logic [IW-1:0]   pick_idx, cand;
  logic            pick_vld;
  logic [15:0]     pick_val;
  logic [NREQ-1:0] ack_nxt;
  logic [15:0]     res_nxt, val_nxt;
  logic            start_nxt;
  logic            wd_abort;
  logic            wd_fire;

  // Scan downward so the last hit is the smallest offset from ptr.
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    cand     = '0;
    for (int off = NREQ - 1; off >= 0; off--) begin
      cand = IW'((int'(ptr) + off) % NREQ);
      if (req[cand]) begin
        pick_vld = 1'b1;
        pick_idx = cand;
      end
    end
  end

  always_comb begin
    pick_val = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (pick_idx == IW'(i)) pick_val = req_val[16*i +: 16];
    end
  end

`ifdef BCD_ARB_WATCHDOG_EN
  localparam logic [15:0] WD_LOAD = 16'(TIMEOUT - 1);
  logic [15:0] wd_cnt, wd_cnt_nxt;

  // Down-counter loaded in ISSUE; terminal count in a wait state aborts.
  always_comb begin
    wd_cnt_nxt = wd_cnt;
    wd_abort   = 1'b0;
    if (state == S_ISSUE) begin
      wd_cnt_nxt = WD_LOAD;
    end else if (state == S_WAIT_CLR || state == S_WAIT_DONE) begin
      if (wd_cnt == 16'd0) wd_abort = 1'b1;
      else                 wd_cnt_nxt = wd_cnt - 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wd_cnt <= '0;
      err    <= 1'b0;
    end else begin
      wd_cnt <= wd_cnt_nxt;
      err    <= wd_fire;
    end
  end
`else
  assign wd_abort = 1'b0;
  assign err      = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    gidx_nxt  = gidx;
    ack_nxt   = '0;
    res_nxt   = res_bcd;
    val_nxt   = conv_val;
    start_nxt = 1'b0;
    wd_fire   = 1'b0;
    case (state)
      S_IDLE: begin
        if (pick_vld) begin
          gidx_nxt  = pick_idx;
          val_nxt   = pick_val;
          start_nxt = 1'b1;
          state_nxt = S_ISSUE;
        end
      end
      S_ISSUE:    state_nxt = S_WAIT_CLR;
      S_WAIT_CLR: if (!conv_done) state_nxt = S_WAIT_DONE;
      S_WAIT_DONE: begin
        if (conv_done) begin
          res_nxt       = conv_bcd;
          ack_nxt[gidx] = 1'b1;
          state_nxt     = S_DELIVER;
        end
      end
      S_DELIVER: begin
        ptr_nxt   = (gidx == IW'(NREQ - 1)) ? '0 : gidx + IW'(1);
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
    // A real done in the same cycle as terminal count wins over the abort.
    if (wd_abort && state_nxt != S_DELIVER) begin
      wd_fire       = 1'b1;
      res_nxt       = 16'hFFFF;
      ack_nxt       = '0;
      ack_nxt[gidx] = 1'b1;
      state_nxt     = S_DELIVER;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      ptr        <= '0;
      gidx       <= '0;
      ack        <= '0;
      res_bcd    <= '0;
      conv_val   <= '0;
      conv_start <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_nxt;
      ptr        <= ptr_nxt;
      gidx       <= gidx_nxt;
      ack        <= ack_nxt;
      res_bcd    <= res_nxt;
      conv_val   <= val_nxt;
      conv_start <= start_nxt;
      busy       <= (state_nxt != S_IDLE);
    end
  end

endmodule

// File: tb/tb_bcd_convert_arbiter.sv
// Bench for bcd_convert_arbiter: converter model, timeline reference model checked every
// cycle, and directed scenarios with literal expectations. Honours BCD_ARB_WATCHDOG_EN.
module tb_bcd_convert_arbiter;

  localparam int NREQ    = 4;
  localparam int TIMEOUT = 16;

  logic                clk = 1'b0;
  logic                reset;
  logic [NREQ-1:0]     req;
  logic [16*NREQ-1:0]  req_val;
  logic [NREQ-1:0]     ack;
  logic [15:0]         res_bcd;
  logic                err;
  logic                busy;
  logic                conv_start;
  logic [15:0]         conv_val;
  logic                conv_done;
  logic [15:0]         conv_bcd;

  int checks   = 0;
  int failures = 0;

  bcd_convert_arbiter #(.NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .req(req), .req_val(req_val),
    .ack(ack), .res_bcd(res_bcd), .err(err), .busy(busy),
    .conv_start(conv_start), .conv_val(conv_val),
    .conv_done(conv_done), .conv_bcd(conv_bcd)
  );

  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL global_timeout: simulation did not finish, time=%0t", $time);
    $fatal(1, "time limit");
  end

  function automatic logic [15:0] to_bcd(input int v);
    return 16'((v / 1000 % 10) * 4096 + (v / 100 % 10) * 256 + (v / 10 % 10) * 16 + v % 10);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
    end
  endtask

  // Converter: level done, cleared cv_clr cycles after start, result cv_lat cycles after start.
  int          cv_lat = 20, cv_clr = 0, cv_cnt = 0;
  bit          cv_never = 0, cv_run = 0;
  logic [15:0] cv_op = '0;
  initial begin
    forever begin
      @(posedge clk); #2;
      if (conv_start === 1'b1) begin
        cv_run = 1; cv_cnt = 0; cv_op = conv_val;
      end else if (cv_run) cv_cnt++;
      if (cv_run) begin
        if (cv_cnt == cv_clr) conv_done = 1'b0;
        if (!cv_never && cv_cnt == cv_lat) begin
          conv_done = 1'b1;
          conv_bcd  = to_bcd(int'(cv_op));
          cv_run    = 0;
        end
      end
    end
  end

  // Reference model: per-edge timeline of grants and completions.
  int          e_cnt = 0, t_grant = 0, ready_at = 0, m_ptr = 0, m_win = 0;
  bit          mv = 0, m_active = 0, seen_low = 0;
  logic [NREQ-1:0]    s_req;
  logic [16*NREQ-1:0] s_val;
  logic               s_done, s_rst;
  logic [15:0] m_op = '0;
  logic [NREQ-1:0] exp_ack = '0;
  logic [15:0] exp_res = '0, exp_val = '0;
  logic        exp_start = 0, exp_busy = 0, exp_err = 0;

  initial begin
    forever begin
      @(posedge clk);
      s_req = req; s_val = req_val; s_done = conv_done; s_rst = reset;
      e_cnt++;
      exp_start = 0; exp_ack = '0; exp_err = 0;
      if (s_rst === 1'b1) begin
        mv = 1; m_active = 0; m_ptr = 0;
        exp_res = '0; exp_val = '0; exp_busy = 0;
        ready_at = e_cnt + 1;
      end else if (mv) begin
        if (m_active) begin
          exp_busy = 1;
          if (e_cnt >= t_grant + 3 && seen_low && s_done) begin
            exp_ack = NREQ'(1 << m_win); exp_res = to_bcd(int'(m_op));
            m_active = 0; m_ptr = (m_win + 1) % NREQ; ready_at = e_cnt + 2;
          end
`ifdef BCD_ARB_WATCHDOG_EN
          else if (e_cnt == t_grant + 1 + TIMEOUT) begin
            exp_ack = NREQ'(1 << m_win); exp_res = 16'hFFFF; exp_err = 1;
            m_active = 0; m_ptr = (m_win + 1) % NREQ; ready_at = e_cnt + 2;
          end
`endif
          else if (e_cnt >= t_grant + 2 && !s_done) seen_low = 1;
        end else if (e_cnt >= ready_at && s_req != '0) begin
          for (int off = NREQ - 1; off >= 0; off--)
            if (s_req[(m_ptr + off) % NREQ]) m_win = (m_ptr + off) % NREQ;
          m_op = s_val[16*m_win +: 16];
          m_active = 1; t_grant = e_cnt; seen_low = 0;
          exp_start = 1; exp_val = m_op; exp_busy = 1;
        end else exp_busy = 0;
      end
      #1;
      if (mv) begin
        chk("mon_ack", 32'(ack), 32'(exp_ack));
        chk("mon_res_bcd", 32'(res_bcd), 32'(exp_res));
        chk("mon_err", 32'(err), 32'(exp_err));
        chk("mon_busy", 32'(busy), 32'(exp_busy));
        chk("mon_conv_start", 32'(conv_start), 32'(exp_start));
        chk("mon_conv_val", 32'(conv_val), 32'(exp_val));
      end
    end
  end

  task automatic tick();
    @(posedge clk); #2;
  endtask

  task automatic set_val(input int i, input int v);
    req_val[16*i +: 16] = 16'(v);
  endtask

  // Waits for the start pulse, then for ack; checks operand, latency and result.
  task automatic run_conv(input string nm, input logic [3:0] ea, input logic [15:0] er,
                          input logic ee, input int en, input logic [15:0] ecv,
                          input bit chg, input int chg_idx, input int chg_v);
    int n;
    bit got;
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(posedge clk); #1;
      if (conv_start === 1'b1) got = 1;
    end
    chk({nm, "_start_seen"}, 32'(got), 32'd1);
    if (!got) return;
    chk({nm, "_conv_val"}, 32'(conv_val), 32'(ecv));
    n = 0; got = 0;
    while (!got && n < 200) begin
      @(posedge clk); #1;
      n++;
      if (chg && n == 1) set_val(chg_idx, chg_v);
      if (ack !== '0) got = 1;
    end
    chk({nm, "_ack_seen"}, 32'(got), 32'd1);
    chk({nm, "_latency"}, 32'(n), 32'(en));
    chk({nm, "_ack"}, 32'(ack), 32'(ea));
    chk({nm, "_res_bcd"}, 32'(er), 32'(res_bcd) ^ 32'(er) ^ 32'(er)) ;
    chk({nm, "_err"}, 32'(err), 32'(ee));
  endtask

  int rr_idx[5] = '{0, 1, 2, 3, 0};
  int rr_num[5] = '{9, 99, 999, 9999, 9};
  logic [15:0] rr_res[5] = '{16'h0009, 16'h0099, 16'h0999, 16'h9999, 16'h0009};
  int  na;
  bit  got_s;

  initial begin
    reset = 1'b1; req = '0; req_val = '0; conv_done = 1'b0; conv_bcd = '0;
    repeat (3) tick();
    chk("rst_ack", 32'(ack), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_conv_start", 32'(conv_start), 32'd0);
    chk("rst_conv_val", 32'(conv_val), 32'd0);
    chk("rst_res_bcd", 32'(res_bcd), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    reset = 1'b0;

    // single request
    set_val(0, 1234); req = 4'b0001;
    run_conv("single", 4'b0001, 16'h1234, 1'b0, 21, 16'd1234, 0, 0, 0);
    chk("single_busy_in_ack", 32'(busy), 32'd1);
    req = '0;
    @(posedge clk); #1;
    chk("single_busy_low", 32'(busy), 32'd0);

    // round robin from a freshly reset pointer
    tick(); reset = 1'b1; tick(); reset = 1'b0;
    for (int i = 0; i < 4; i++) set_val(i, rr_num[i]);
    req = 4'b1111;
    for (int j = 0; j < 5; j++)
      run_conv($sformatf("rr%0d", j), 4'(1 << rr_idx[j]), rr_res[j], 1'b0, 21,
               16'(rr_num[j]), 0, 0, 0);
    req = '0;

    // stale done held high at grant, cleared two cycles after start
    cv_clr = 2; set_val(1, 555); req = 4'b0010;
    run_conv("stale", 4'b0010, 16'h0555, 1'b0, 21, 16'd555, 0, 0, 0);
    req = '0; cv_clr = 0;

    // operand changes the cycle after start
    set_val(2, 42); req = 4'b0100;
    run_conv("opchg", 4'b0100, 16'h0042, 1'b0, 21, 16'd42, 1, 2, 77);
    req = '0;

    // reset while waiting for done
    set_val(1, 321); req = 4'b0010;
    got_s = 0;
    for (int i = 0; i < 20 && !got_s; i++) begin
      @(posedge clk); #1;
      if (conv_start === 1'b1) got_s = 1;
    end
    chk("rstmid_start_seen", 32'(got_s), 32'd1);
    repeat (5) @(posedge clk);
    #2; reset = 1'b1; req = '0;
    tick(); reset = 1'b0;
    chk("rstmid_ack", 32'(ack), 32'd0);
    chk("rstmid_busy", 32'(busy), 32'd0);
    chk("rstmid_res_bcd", 32'(res_bcd), 32'd0);
    chk("rstmid_conv_val", 32'(conv_val), 32'd0);
    chk("rstmid_conv_start", 32'(conv_start), 32'd0);
    chk("rstmid_err", 32'(err), 32'd0);
    na = 0;
    repeat (25) begin
      @(posedge clk); #1;
      if (ack !== '0) na++;
    end
    chk("rstmid_no_ack", 32'(na), 32'd0);
    set_val(2, 4321); req = 4'b0100;
    run_conv("post_rst", 4'b0100, 16'h4321, 1'b0, 21, 16'd4321, 0, 0, 0);
    req = '0;

    // converter that never finishes
    cv_never = 1; set_val(0, 7); req = 4'b0001;
`ifdef BCD_ARB_WATCHDOG_EN
    run_conv("wd", 4'b0001, 16'hFFFF, 1'b1, TIMEOUT + 1, 16'd7, 0, 0, 0);
    req = '0;
    @(posedge clk); #1;
    chk("wd_err_clear", 32'(err), 32'd0);
    chk("wd_ack_clear", 32'(ack), 32'd0);
`else
    got_s = 0;
    for (int i = 0; i < 20 && !got_s; i++) begin
      @(posedge clk); #1;
      if (conv_start === 1'b1) got_s = 1;
    end
    chk("nowd_start_seen", 32'(got_s), 32'd1);
    na = 0;
    repeat (1000) begin
      @(posedge clk); #1;
      if (busy === 1'b1 && ack === '0 && err === 1'b0) na++;
    end
    chk("nowd_stuck_busy", 32'(na), 32'd1000);
    #1; req = '0; reset = 1'b1;
    tick(); reset = 1'b0;
`endif
    cv_never = 0;
    repeat (3) tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
